// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready handshakes on both sides and full back-pressure.
// Define ALU_MUL_EN to add an iterative radix-2 shift-add multiplier on opcode 4'b1100.
module alu_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_lhs,
  input  logic [XLEN-1:0] in_rhs,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  output logic [3:0]      out_flags
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_ADDU = 4'b1010;
  localparam logic [3:0] OP_SUBU = 4'b1011;

  logic            s1_valid_r;
  logic [3:0]      s1_op_r;
  logic [XLEN-1:0] s1_lhs_r;
  logic [XLEN-1:0] s1_rhs_r;
  logic            s2_valid_r;
  logic [XLEN-1:0] s2_res_r;
  logic [3:0]      s2_flags_r;

  logic            s1_adv_s;
  logic            accept_s;
  logic [XLEN:0]   sum_s;
  logic [XLEN:0]   dif_s;
  logic [SHW-1:0]  shamt_s;
  logic [XLEN-1:0] res_s;
  logic            carry_s;
  logic            ovf_s;
  logic [3:0]      flags_s;

`ifdef ALU_MUL_EN
  localparam logic [3:0]   OP_MUL   = 4'b1100;
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(XLEN-1);

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

  mul_state_t        mul_state_r;
  mul_state_t        mul_state_s;
  logic [SHW:0]      mul_cnt_r;
  logic [2*XLEN-1:0] mul_acc_r;
  logic [2*XLEN-1:0] mul_mcand_r;
  logic [XLEN-1:0]   mul_mplier_r;
  logic              mul_start_s;

  // Handshake control: a multiply in S1 only advances once its product is complete.
  always_comb begin
    mul_start_s = s1_valid_r && (s1_op_r == OP_MUL);
    s1_adv_s    = s1_valid_r && (!s2_valid_r || out_ready) &&
                  ((s1_op_r != OP_MUL) || (mul_state_r == MUL_DONE));
    in_ready    = (mul_state_r == MUL_IDLE) && (!s1_valid_r || s1_adv_s);
  end

  // Multiplier FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_state_r <= MUL_IDLE;
    end else begin
      mul_state_r <= mul_state_s;
    end
  end

  // Multiplier FSM next state: the first partial product is taken on the IDLE->BUSY edge.
  always_comb begin
    mul_state_s = mul_state_r;
    case (mul_state_r)
      MUL_IDLE: begin
        if (mul_start_s) mul_state_s = MUL_BUSY;
        else             mul_state_s = MUL_IDLE;
      end
      MUL_BUSY: begin
        if (mul_cnt_r == CNT_LAST) mul_state_s = MUL_DONE;
        else                       mul_state_s = MUL_BUSY;
      end
      MUL_DONE: begin
        if (s1_adv_s) mul_state_s = MUL_IDLE;
        else          mul_state_s = MUL_DONE;
      end
      default: mul_state_s = MUL_IDLE;
    endcase
  end

  // Shift-add datapath: one multiplier bit per cycle, XLEN steps in total.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_cnt_r    <= '0;
      mul_acc_r    <= '0;
      mul_mcand_r  <= '0;
      mul_mplier_r <= '0;
    end else if ((mul_state_r == MUL_IDLE) && mul_start_s) begin
      mul_cnt_r    <= (SHW+1)'(1);
      mul_acc_r    <= s1_rhs_r[0] ? {{XLEN{1'b0}}, s1_lhs_r} : {(2*XLEN){1'b0}};
      mul_mcand_r  <= {{(XLEN-1){1'b0}}, s1_lhs_r, 1'b0};
      mul_mplier_r <= {1'b0, s1_rhs_r[XLEN-1:1]};
    end else if (mul_state_r == MUL_BUSY) begin
      mul_cnt_r    <= mul_cnt_r + (SHW+1)'(1);
      if (mul_mplier_r[0]) mul_acc_r <= mul_acc_r + mul_mcand_r;
      mul_mcand_r  <= mul_mcand_r << 1;
      mul_mplier_r <= mul_mplier_r >> 1;
    end
  end
`else
  // Handshake control; in_ready sees out_ready combinationally so both ends can move in one cycle.
  always_comb begin
    s1_adv_s = s1_valid_r && (!s2_valid_r || out_ready);
    in_ready = !s1_valid_r || s1_adv_s;
  end
`endif

  assign accept_s = in_valid && in_ready;

  // S1 compute: result and flags of the operation held in the operand register.
  always_comb begin
    sum_s   = {1'b0, s1_lhs_r} + {1'b0, s1_rhs_r};
    dif_s   = {1'b0, s1_lhs_r} - {1'b0, s1_rhs_r};
    shamt_s = s1_rhs_r[SHW-1:0];
    res_s   = {XLEN{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (s1_op_r)
      OP_ADD, OP_ADDU: begin
        res_s   = sum_s[XLEN-1:0];
        carry_s = sum_s[XLEN];
        ovf_s   = (s1_lhs_r[XLEN-1] == s1_rhs_r[XLEN-1]) && (sum_s[XLEN-1] != s1_lhs_r[XLEN-1]);
      end
      OP_SUB, OP_SUBU: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        res_s   = dif_s[XLEN-1:0];
        carry_s = dif_s[XLEN];
        ovf_s   = (s1_lhs_r[XLEN-1] != s1_rhs_r[XLEN-1]) && (dif_s[XLEN-1] != s1_lhs_r[XLEN-1]);
      end
      OP_SLL:  res_s = s1_lhs_r << shamt_s;
      OP_SLT:  res_s = {{(XLEN-1){1'b0}}, ($signed(s1_lhs_r) < $signed(s1_rhs_r))};
      OP_SLTU: res_s = {{(XLEN-1){1'b0}}, (s1_lhs_r < s1_rhs_r)};
      OP_XOR:  res_s = s1_lhs_r ^ s1_rhs_r;
      OP_SRL:  res_s = s1_lhs_r >> shamt_s;
      OP_OR:   res_s = s1_lhs_r | s1_rhs_r;
      OP_AND:  res_s = s1_lhs_r & s1_rhs_r;
      OP_SRA:  res_s = XLEN'($signed(s1_lhs_r) >>> shamt_s);
`ifdef ALU_MUL_EN
      OP_MUL: begin
        res_s = mul_acc_r[XLEN-1:0];
        ovf_s = |mul_acc_r[2*XLEN-1:XLEN];
      end
`endif
      default: res_s = {XLEN{1'b0}};
    endcase
    flags_s = {(res_s == {XLEN{1'b0}}), res_s[XLEN-1], carry_s, ovf_s};
  end

  // S1 operand register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 4'b0000;
      s1_lhs_r   <= {XLEN{1'b0}};
      s1_rhs_r   <= {XLEN{1'b0}};
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_op_r    <= in_op;
      s1_lhs_r   <= in_lhs;
      s1_rhs_r   <= in_rhs;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // S2 result register; data stays put while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_res_r   <= {XLEN{1'b0}};
      s2_flags_r <= 4'b0000;
    end else if (s1_adv_s) begin
      s2_valid_r <= 1'b1;
      s2_res_r   <= res_s;
      s2_flags_r <= flags_s;
    end else if (out_ready) begin
      s2_valid_r <= 1'b0;
    end
  end

  assign out_valid = s2_valid_r;
  assign out_res   = s2_res_r;
  assign out_flags = s2_flags_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (default build, XLEN=32).
module tb_alu_pipe;

  localparam int XLEN = 32;
  localparam int NV   = 15;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [XLEN-1:0] in_lhs;
  logic [XLEN-1:0] in_rhs;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_res;
  logic [3:0]      out_flags;

  int checks;
  int failures;

  logic [3:0]      v_op    [NV];
  logic [XLEN-1:0] v_lhs   [NV];
  logic [XLEN-1:0] v_rhs   [NV];
  logic [XLEN-1:0] v_res   [NV];
  logic [3:0]      v_flags [NV];

  alu_pipe #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_lhs    (in_lhs),
    .in_rhs    (in_rhs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [XLEN-1:0] lhs, input logic [XLEN-1:0] rhs);
    in_op  = op;
    in_lhs = lhs;
    in_rhs = rhs;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [3:0] op, input logic [XLEN-1:0] lhs,
                         input logic [XLEN-1:0] rhs, input logic [XLEN-1:0] res, input logic [3:0] flags);
    v_op[i]    = op;
    v_lhs[i]   = lhs;
    v_rhs[i]   = rhs;
    v_res[i]   = res;
    v_flags[i] = flags;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    set_vec(0,  4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101);
    set_vec(1,  4'b1011, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0110);
    set_vec(2,  4'b1001, 32'h80000000, 32'd33,       32'hC0000000, 4'b0100);
    set_vec(3,  4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000);
    set_vec(4,  4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000);
    set_vec(5,  4'b0100, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 4'b1000);
    set_vec(6,  4'b1010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010);
    set_vec(7,  4'b1000, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001);
    set_vec(8,  4'b0001, 32'h00000001, 32'd31,       32'h80000000, 4'b0100);
    set_vec(9,  4'b0101, 32'h80000000, 32'd4,        32'h08000000, 4'b0000);
    set_vec(10, 4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b1000);
    set_vec(11, 4'b1100, 32'h00000003, 32'h00000005, 32'h00000000, 4'b1000);
    set_vec(12, 4'b1000, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b0110);
    set_vec(13, 4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0100);
    set_vec(14, 4'b0101, 32'h00000100, 32'd36,       32'h00000010, 4'b0000);

    // Reset held for two cycles.
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(4'b0000, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_res",   {32'b0, out_res},   64'd0);
    chk("rst_out_flags", {60'b0, out_flags}, 64'd0);
    chk("rst_in_ready",  {63'b0, in_ready},  64'd1);

    // Back-to-back stream with out_ready=1: each result appears two edges after it is offered.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        in_valid = 1'b1;
        drive(v_op[i], v_lhs[i], v_rhs[i]);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i == 0) begin
        chk("latency_no_early_valid", {63'b0, out_valid}, 64'd0);
      end else begin
        chk($sformatf("stream_valid[%0d]", i-1), {63'b0, out_valid}, 64'd1);
        chk($sformatf("stream_res[%0d]",   i-1), {32'b0, out_res},   {32'b0, v_res[i-1]});
        chk($sformatf("stream_flags[%0d]", i-1), {60'b0, out_flags}, {60'b0, v_flags[i-1]});
        chk($sformatf("stream_in_ready[%0d]", i-1), {63'b0, in_ready}, 64'd1);
      end
    end
    step();
    chk("stream_drained", {63'b0, out_valid}, 64'd0);

    // Back-pressure: consumer stalls for five cycles while three ops are offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(4'b0000, 32'h00000001, 32'h00000002);
    step();
    chk("bp_in_ready_after_1", {63'b0, in_ready},  64'd1);
    chk("bp_valid_after_1",    {63'b0, out_valid}, 64'd0);
    drive(4'b0110, 32'h000000F0, 32'h0000000F);
    step();
    chk("bp_in_ready_after_2", {63'b0, in_ready},  64'd0);
    chk("bp_valid_after_2",    {63'b0, out_valid}, 64'd1);
    chk("bp_res_after_2",      {32'b0, out_res},   64'h3);
    drive(4'b0111, 32'hFF00FF00, 32'h0F0F0F0F);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("bp_hold_res[%0d]",      k), {32'b0, out_res},   64'h3);
      chk($sformatf("bp_hold_flags[%0d]",    k), {60'b0, out_flags}, 64'h0);
      chk($sformatf("bp_hold_valid[%0d]",    k), {63'b0, out_valid}, 64'd1);
      chk($sformatf("bp_hold_in_ready[%0d]", k), {63'b0, in_ready},  64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", {63'b0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_res_b",   {32'b0, out_res},   64'hFF);
    chk("bp_flags_b", {60'b0, out_flags}, 64'h0);
    chk("bp_valid_b", {63'b0, out_valid}, 64'd1);
    step();
    chk("bp_res_c",   {32'b0, out_res},   64'h0F000F00);
    chk("bp_flags_c", {60'b0, out_flags}, 64'h0);
    chk("bp_valid_c", {63'b0, out_valid}, 64'd1);
    step();
    chk("bp_drained", {63'b0, out_valid}, 64'd0);

    // Reset while an op sits in S1: it must never be emitted.
    in_valid = 1'b1;
    drive(4'b0000, 32'h00000005, 32'h00000006);
    step();
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_valid",    {63'b0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'b0, in_ready},  64'd1);
    step();
    chk("midrst_valid_next", {63'b0, out_valid}, 64'd0);
    chk("midrst_res_next",   {32'b0, out_res},   64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
